// File: rtl/led_pattern_pkg.sv
// Shared types and helpers for the multi-channel LED pattern generator.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  // Binary-weighted reset divider: 2^ch-1, saturating to all-ones once ch >= div_bits.
  function automatic int unsigned default_div(input int unsigned ch, input int unsigned div_bits);
    if (div_bits >= 32) return '1;
    if (ch >= div_bits) return (32'd1 << div_bits) - 32'd1;
    return (32'd1 << ch) - 32'd1;
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds mode, divider, phase counter and breathing duty state.
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int unsigned DIV_BITS = 6,
  parameter int unsigned PWM_BITS = 4,
  parameter mode_e       RST_MODE = MODE_BLINK,
  parameter int unsigned RST_DIV  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                load,
  input  mode_e               load_mode,
  input  logic [DIV_BITS-1:0] load_div,
  output logic                led
);

  mode_e               mode;
  logic [DIV_BITS-1:0] div;
  logic [DIV_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] duty;
  logic                dir_down;

  // A load takes priority over a coincident tick, so the tick is dropped for this channel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode     <= RST_MODE;
      div      <= DIV_BITS'(RST_DIV);
      cnt      <= '0;
      duty     <= '0;
      dir_down <= 1'b0;
      led      <= 1'b0;
    end else if (load) begin
      mode     <= load_mode;
      div      <= load_div;
      cnt      <= '0;
      duty     <= '0;
      dir_down <= 1'b0;
      led      <= 1'b0;
    end else begin
      case (mode)
        MODE_OFF: led <= 1'b0;
        MODE_ON:  led <= 1'b1;
        MODE_BLINK: begin
          if (tick) begin
            if (cnt == div) begin
              cnt <= '0;
              led <= ~led;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        MODE_BREATHE: begin
          led <= (pwm_cnt < duty);
          if (tick) begin
            if (cnt == div) begin
              cnt <= '0;
              // Turn around at the rails instead of wrapping.
              if (!dir_down) begin
                if (duty == '1) begin
                  dir_down <= 1'b1;
                  duty     <= duty - 1'b1;
                end else begin
                  duty <= duty + 1'b1;
                end
              end else begin
                if (duty == '0) begin
                  dir_down <= 1'b0;
                  duty     <= duty + 1'b1;
                end else begin
                  duty <= duty - 1'b1;
                end
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: led <= 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared prescaler/PWM timebase feeding per-channel pattern state.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int unsigned NUM_LEDS      = 4,
  parameter int unsigned PRESCALE_BITS = 3,
  parameter int unsigned DIV_BITS      = 6,
  parameter int unsigned PWM_BITS      = 4,
  parameter mode_e       RESET_MODE    = MODE_BLINK,
  // May be widened beyond the minimum so out-of-range channels can be addressed.
  parameter int unsigned CH_BITS       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_BITS-1:0]  cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [DIV_BITS-1:0] cfg_div,
  output logic                cfg_err,
  output logic                tick,
  output logic [NUM_LEDS-1:0] led
);

  logic [PRESCALE_BITS-1:0] pre;
  logic [PWM_BITS-1:0]      pwm_cnt;
  logic                     accept;
  logic                     ch_valid;
  logic [NUM_LEDS-1:0]      load;

  assign tick     = (pre == '1);
  assign accept   = cfg_valid && cfg_ready;
  assign ch_valid = (32'(cfg_ch) < NUM_LEDS);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre       <= '0;
      pwm_cnt   <= '0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      pre       <= pre + 1'b1;
      pwm_cnt   <= pwm_cnt + 1'b1;
      cfg_ready <= 1'b1;
      cfg_err   <= accept && !ch_valid;
    end
  end

  always_comb begin
    load = '0;
    for (int unsigned c = 0; c < NUM_LEDS; c++) begin
      if (accept && (32'(cfg_ch) == c)) load[c] = 1'b1;
    end
  end

  for (genvar c = 0; c < NUM_LEDS; c++) begin : g_ch
    led_channel #(
      .DIV_BITS (DIV_BITS),
      .PWM_BITS (PWM_BITS),
      .RST_MODE (RESET_MODE),
      .RST_DIV  (default_div(c, DIV_BITS))
    ) u_channel (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .pwm_cnt   (pwm_cnt),
      .load      (load[c]),
      .load_mode (mode_e'(cfg_mode)),
      .load_div  (cfg_div),
      .led       (led[c])
    );
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with PRESCALE_BITS=2, DIV_BITS=4, PWM_BITS=2, NUM_LEDS=4.
module tb_led_pattern_gen;
  import led_pattern_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [2:0] cfg_ch = '0;
  logic [1:0] cfg_mode = '0;
  logic [3:0] cfg_div = '0;
  logic       cfg_err;
  logic       tick;
  logic [3:0] led;

  int          checks = 0;
  int          fails = 0;
  int unsigned cyc = 0;

  led_pattern_gen #(
    .NUM_LEDS      (4),
    .PRESCALE_BITS (2),
    .DIV_BITS      (4),
    .PWM_BITS      (2),
    .RESET_MODE    (MODE_BLINK),
    .CH_BITS       (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_div   (cfg_div),
    .cfg_err   (cfg_err),
    .tick      (tick),
    .led       (led)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic [2:0] ch, input logic [1:0] mode, input logic [3:0] div);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_mode  = mode;
    cfg_div   = div;
  endtask

  // Free-running reset pattern: led[c] toggles every 4*2^c edges after release.
  function automatic logic [3:0] exp_default(input int unsigned e);
    logic [3:0] v;
    for (int c = 0; c < 4; c++) v[c] = ((e >> (c + 2)) & 1) != 0;
    return v;
  endfunction

  // Expected LEDs for the first run, given the scripted writes at edges 41, 51, 53, 91, 128.
  function automatic logic [3:0] exp_vec(input int unsigned e);
    logic [3:0]  v;
    logic [3:0]  d;
    int unsigned f, k, duty;
    d = exp_default(e);
    if (e < 91) v[0] = d[0];
    else if (e < 93) v[0] = 1'b0;
    else begin
      f = ((e - 1) / 4) * 4;
      k = (f - 92) / 4;
      case (k % 6)
        0: duty = 1;
        1: duty = 2;
        2: duty = 3;
        3: duty = 2;
        4: duty = 1;
        default: duty = 0;
      endcase
      v[0] = ((e - 1) % 4) < duty;
    end
    if (e < 53) v[1] = d[1];
    else if (e < 64) v[1] = 1'b0;
    else v[1] = (((e - 64) / 12) % 2) == 0;
    if (e < 41) v[2] = d[2];
    else if (e == 41) v[2] = 1'b0;
    else v[2] = (e <= 50);
    if (e < 128) v[3] = d[3];
    else if (e < 136) v[3] = 1'b0;
    else v[3] = (((e - 136) / 8) % 2) == 0;
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    step();
    step();
    checks++; if (led !== 4'b0000) begin fails++; $display("FAIL reset_led: got %b expected 0000", led); end
    checks++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", cfg_ready); end
    checks++; if (tick !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b expected 0", tick); end
    checks++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", cfg_err); end
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (led !== exp_vec(cyc)) begin fails++; $display("FAIL default_led@%0d: got %b expected %b", cyc, led, exp_vec(cyc)); end
      if (cyc == 1) begin
        checks++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL ready_after_release: got %b expected 1", cfg_ready); end
      end
      if (cyc == 3) begin
        checks++; if (tick !== 1'b1) begin fails++; $display("FAIL first_tick: got %b expected 1", tick); end
      end
      if (cyc == 4) begin
        checks++; if (tick !== 1'b0) begin fails++; $display("FAIL tick_width: got %b expected 0", tick); end
      end
    end
  endtask

  task automatic test_on_off();
    while (cyc < 52) begin
      if (cyc == 40) drive(3'd2, 2'd1, 4'd0);
      if (cyc == 50) drive(3'd2, 2'd0, 4'd0);
      step();
      cfg_valid = 1'b0;
      checks++;
      if (led !== exp_vec(cyc)) begin fails++; $display("FAIL on_off_led@%0d: got %b expected %b", cyc, led, exp_vec(cyc)); end
    end
  endtask

  task automatic test_blink_div();
    while (cyc < 90) begin
      if (cyc == 52) drive(3'd1, 2'd2, 4'd2);
      step();
      cfg_valid = 1'b0;
      checks++;
      if (led !== exp_vec(cyc)) begin fails++; $display("FAIL blink_div_led@%0d: got %b expected %b", cyc, led, exp_vec(cyc)); end
    end
  endtask

  task automatic test_breathe();
    while (cyc < 124) begin
      if (cyc == 90) drive(3'd0, 2'd3, 4'd0);
      step();
      cfg_valid = 1'b0;
      checks++;
      if (led !== exp_vec(cyc)) begin fails++; $display("FAIL breathe_led@%0d: got %b expected %b", cyc, led, exp_vec(cyc)); end
    end
  endtask

  task automatic test_cfg_err_and_tick_collision();
    while (cyc < 144) begin
      if (cyc == 124) drive(3'd5, 2'd1, 4'd0);
      if (cyc == 127) drive(3'd3, 2'd2, 4'd1);
      step();
      cfg_valid = 1'b0;
      checks++;
      if (led !== exp_vec(cyc)) begin fails++; $display("FAIL err_collision_led@%0d: got %b expected %b", cyc, led, exp_vec(cyc)); end
      if (cyc == 125) begin
        checks++; if (cfg_err !== 1'b1) begin fails++; $display("FAIL cfg_err_pulse: got %b expected 1", cfg_err); end
      end
      if (cyc == 126 || cyc == 128) begin
        checks++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL cfg_err_clear@%0d: got %b expected 0", cyc, cfg_err); end
      end
      if (cyc == 128) begin
        checks++; if (tick !== 1'b0) begin fails++; $display("FAIL tick_phase@128: got %b expected 0", tick); end
      end
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    drive(3'd0, 2'd1, 4'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (led !== 4'b0000) begin fails++; $display("FAIL midreset_led: got %b expected 0000", led); end
      checks++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL midreset_ready: got %b expected 0", cfg_ready); end
    end
    rst_n = 1'b1;
    cfg_valid = 1'b0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (led !== exp_default(cyc)) begin fails++; $display("FAIL post_reset_led@%0d: got %b expected %b", cyc, led, exp_default(cyc)); end
      if (cyc == 1) begin
        checks++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL post_reset_ready: got %b expected 1", cfg_ready); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    while (cyc < 48) begin
      if (cyc == 40) drive(3'd2, 2'd1, 4'd0);
      if (cyc == 41) drive(3'd3, 2'd1, 4'd0);
      step();
      if (cyc == 42) cfg_valid = 1'b0;
      exp    = exp_default(cyc);
      exp[2] = (cyc >= 42);
      if (cyc >= 42) exp[3] = (cyc >= 43);
      checks++;
      if (led !== exp) begin fails++; $display("FAIL back_to_back_led@%0d: got %b expected %b", cyc, led, exp); end
      checks++;
      if (cfg_err !== 1'b0) begin fails++; $display("FAIL back_to_back_err@%0d: got %b expected 0", cyc, cfg_err); end
    end
  endtask

  initial begin
    test_reset();
    test_on_off();
    test_blink_div();
    test_breathe();
    test_cfg_err_and_tick_collision();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Multi-channel LED driver that generalises the fixed binary-weighted blinker into a runtime-configurable pattern generator.
- Every channel runs one mode: OFF, ON, BLINK (programmable half-period) or BREATHE (triangle-ramped PWM duty).
- All channels share one prescaler tick so their phases stay aligned.
- Sits at board top between a small config master (host register bridge or VIO) and the LED pins.

Parameters:
NUM_LEDS, 4, number of LED channels (1..16)
PRESCALE_BITS, 3, width of the shared prescaler; one tick every 2^PRESCALE_BITS clk cycles
DIV_BITS, 6, width of the per-channel tick divider; half-period = div+1 ticks
PWM_BITS, 4, PWM resolution; PWM frame = 2^PWM_BITS clk cycles
RESET_MODE, MODE_BLINK, mode loaded into every channel at reset

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
cfg_valid  in  1  config write request
cfg_ready  out  1  config write can be accepted
cfg_ch  in  max(1,$clog2(NUM_LEDS))  target channel
cfg_mode  in  2  mode_e: 0 OFF, 1 ON, 2 BLINK, 3 BREATHE
cfg_div  in  DIV_BITS  tick divider for BLINK/BREATHE
cfg_err  out  1  one-cycle pulse on write to channel >= NUM_LEDS
tick  out  1  shared prescaler tick, one clk wide
led  out  NUM_LEDS  LED drive, active high, registered

Behaviour:
Reset:
- Applied on a clk edge with rst_n=0.
- pre=0, pwm_cnt=0, led=0, tick=0, cfg_ready=0, cfg_err=0.
- Per channel c: mode=RESET_MODE, cnt=0, duty=0, dir=up.
- div[c] = 2^c-1, saturated to all-ones when c >= DIV_BITS. This preserves the binary-weighted blink out of reset.
- cfg_ready=1 from the first edge after rst_n returns high; it stays 1 thereafter.

Prescaler:
- pre increments every clk and wraps.
- tick is high while pre==2^PRESCALE_BITS-1. The first tick comes 2^PRESCALE_BITS cycles after reset release.

Shared PWM counter:
- pwm_cnt increments every clk and wraps at 2^PWM_BITS.

Per channel, evaluated on each edge:
- OFF: led=0. cnt, duty and dir hold.
- ON: led=1.
- BLINK: on tick, if cnt==div then cnt<=0 and led toggles; else cnt<=cnt+1. Without a tick, everything holds.
- BREATHE:
  - led <= (pwm_cnt < duty), unsigned compare. duty=0 gives constant 0.
  - On tick with cnt==div: cnt<=0 and duty steps by 1 in direction dir.
  - At duty==2^PWM_BITS-1 going up, dir flips to down and the next step is -1. At duty==0 going down, dir flips to up.
  - duty never wraps.
- div is compared full width; div=0 means an event every tick.

Config handshake:
- A write is accepted when cfg_valid && cfg_ready.
- Valid channel: on that edge, mode and div are loaded and cnt=0, led=0, duty=0, dir=up. The new mode drives led from the following edge.
- Invalid channel (cfg_ch >= NUM_LEDS): no state changes; cfg_err=1 for exactly the next cycle.
- Back-to-back writes are allowed, one per cycle.

Simultaneous events and corner cases:
- A write and a tick on the same edge for the same channel: the write wins and the tick is lost for that channel. Other channels process the tick normally.
- Changing mode resets phase; rewriting the same mode also resets phase.
- Reset asserted mid-pattern clears all state on the next edge regardless of cfg_valid.

Latency:
- tick to led change: 1 edge.
- Config accept to new-mode output: 1 edge.

Decomposition:
Package led_pattern_pkg:
- mode_e enum (2-bit) with MODE_OFF/ON/BLINK/BREATHE.
- Function that computes the default reset div from channel index and DIV_BITS.

Sub-module led_channel:
- One channel's mode/div/cnt/duty/dir/led state.
- Inputs: tick, pwm_cnt, load strobe, load mode, load div.

Top-level led_pattern_gen holds:
- Prescaler, PWM counter, channel decode, cfg_err.
- Generate loop over led_channel.

Test Plan:
All scenarios use PRESCALE_BITS=2, DIV_BITS=4, PWM_BITS=2, NUM_LEDS=4.
- Reset release, no config: led[0] toggles every 4 clk (first rise at edge 4 after release); led[1] every 8; led[2] every 16; led[3] every 32.
- Write ch2 ON (cfg_valid one cycle): led[2]=1 from the next edge and stays 1; other channels continue undisturbed. Write ch2 OFF: led[2]=0 next edge.
- Write ch1 BLINK div=2: led[1]=0 immediately, then toggles every 12 clk aligned to ticks.
- Write ch0 BREATHE div=0: duty sequence per tick 1,2,3,2,1,0,1... Check led[0] high for exactly duty clks of each 4-clk PWM frame.
- Write cfg_ch=5 with NUM_LEDS=4 (wider cfg_ch build): cfg_err high one cycle; led unchanged. Write to ch3 on a tick edge: ch3 cnt cleared, the tick is ignored for ch3 only.
- rst_n low for 2 clk mid-BREATHE: led=0 and cfg_ready=0 during reset. After release, defaults are restored and the first led[0] toggle occurs at edge 4.
